// File: rtl/bcd_to_bin.sv
// Purpose: packed BCD to binary converter using reverse double-dabble (shift right, then subtract 3 from any nibble >= 8).
// Latency: start sampled at E0 -> done pulses after edge E0+BIN_W+1. A request with an invalid nibble answers one cycle later with err.
// Backpressure: none queued. start is ignored while busy, and the caller must wait for done before issuing the next request.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [SR_W-1:0]   r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  r_bin_out;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_bad;
  logic [SR_W-1:0]   w_shift;
  logic [SR_W-1:0]   w_next;

  // Flag a request if any input nibble is outside the range 0..9.
  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end

  // Perform one iteration: shift right, then correct each BCD nibble that is >= 8. The subtraction cannot underflow.
  always_comb begin
    w_shift = r_sr >> 1;
    w_next  = w_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shift[BIN_W + 4*d +: 4] >= 4'd8) begin
        w_next[BIN_W + 4*d +: 4] = w_shift[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  // Run the conversion FSM with registered outputs. Reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad) begin
              // Reject the request and answer immediately. The previous result stays visible.
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_sr    <= {bcd_in, {BIN_W{1'b0}}};
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_sr  <= w_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
`ifndef SYNTHESIS
          // Once all bits have been shifted out of a valid input, every BCD digit must be zero.
          assert (r_sr[SR_W-1:BIN_W] == '0)
            else $error("bcd_to_bin: BCD field not empty at finish");
`endif
          r_bin_out <= r_sr[BIN_W-1:0];
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule
